// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: generic inter-stage register (valid, control, addresses, data) with stall/flush.
// Saturating bubble/stall performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stage_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_DATA    = 5,
  parameter int                    CTRL_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 15,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = {CTRL_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           valid_in,
  input  logic [CTRL_WIDTH-1:0]          ctrl_in,
  input  logic [ADDR_WIDTH-1:0]          addr_in,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] data_in,
  output logic                           valid_out,
  output logic [CTRL_WIDTH-1:0]          ctrl_out,
  output logic [ADDR_WIDTH-1:0]          addr_out,
  output logic [NUM_DATA*DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]           bubble_cnt,
  output logic [CNT_WIDTH-1:0]           stall_cnt
);

  localparam int DW = NUM_DATA * DATA_WIDTH;

  logic                  valid_r;
  logic [CTRL_WIDTH-1:0] ctrl_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DW-1:0]         data_r;

  // Stage register: rst > flush > stall > load. A bubble also zeroes addresses so
  // forwarding never matches against a dead slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      ctrl_r  <= CTRL_BUBBLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      data_r  <= {DW{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= CTRL_BUBBLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      data_r  <= data_in;
    end else if (stall) begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      addr_r  <= addr_r;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_in;
      ctrl_r  <= valid_in ? ctrl_in : CTRL_BUBBLE;
      addr_r  <= valid_in ? addr_in : {ADDR_WIDTH{1'b0}};
      data_r  <= data_in;
    end
  end

  assign valid_out = valid_r;
  assign ctrl_out  = ctrl_r;
  assign addr_out  = addr_r;
  assign data_out  = data_r;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] bubble_cnt_r;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic                 bubble_evt_s;
  logic                 stall_evt_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Classify this cycle with the same priority as the stage register.
  always_comb begin
    bubble_evt_s = 1'b0;
    stall_evt_s  = 1'b0;
    if (flush) begin
      bubble_evt_s = 1'b1;
    end else if (stall) begin
      stall_evt_s = 1'b1;
    end else if (!valid_in) begin
      bubble_evt_s = 1'b1;
    end else begin
      bubble_evt_s = 1'b0;
    end
  end

  // Saturating event counters; they never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_WIDTH{1'b0}};
      stall_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      bubble_cnt_r <= bubble_evt_s ? sat_inc(bubble_cnt_r) : bubble_cnt_r;
      stall_cnt_r  <= stall_evt_s  ? sat_inc(stall_cnt_r)  : stall_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign stall_cnt  = stall_cnt_r;
`else
  assign bubble_cnt = {CNT_WIDTH{1'b0}};
  assign stall_cnt  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: scoreboard bench for pipeline_stage_reg (CNT_WIDTH=4 to reach saturation).
// Expected counter values follow PIPE_PERF_CNT_EN the same way the design build does.
module tb_pipeline_stage_reg;
  localparam int DW = 32, ND = 5, CW = 16, AW = 15, NW = 4;
  localparam logic [CW-1:0] BUB = 16'h0010;
`ifdef PIPE_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] addr;
    logic [ND*DW-1:0] data;
    logic [NW-1:0] bcnt;
    logic [NW-1:0] scnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [CW-1:0] ctrl_in = 16'h0000;
  logic [AW-1:0] addr_in = 15'h0000;
  logic [ND*DW-1:0] data_in = {(ND*DW){1'b0}};
  logic valid_out;
  logic [CW-1:0] ctrl_out;
  logic [AW-1:0] addr_out;
  logic [ND*DW-1:0] data_out;
  logic [NW-1:0] bubble_cnt, stall_cnt;

  exp_t sb[$];
  exp_t m, e, o;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipeline_stage_reg #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW),
                       .CTRL_BUBBLE(BUB), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ctrl_in(ctrl_in), .addr_in(addr_in), .data_in(data_in),
    .valid_out(valid_out), .ctrl_out(ctrl_out), .addr_out(addr_out), .data_out(data_out),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt));

  function automatic logic [NW-1:0] sat(input logic [NW-1:0] v);
    if (!CNT_EN) return 4'h0;
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

  // Drive one cycle, advance the reference model, push its prediction, then move past the edge.
  task automatic drive(input logic r, s, f, v, input logic [CW-1:0] c,
                       input logic [AW-1:0] a, input logic [ND*DW-1:0] d);
    rst = r; stall = s; flush = f; valid_in = v; ctrl_in = c; addr_in = a; data_in = d;
    if (r) begin
      m = '{valid: 1'b0, ctrl: BUB, addr: 15'h0, data: {(ND*DW){1'b0}}, bcnt: 4'h0, scnt: 4'h0};
    end else if (f) begin
      m.valid = 1'b0; m.ctrl = BUB; m.addr = 15'h0; m.data = d; m.bcnt = sat(m.bcnt);
    end else if (s) begin
      m.scnt = sat(m.scnt);
    end else begin
      m.valid = v; m.ctrl = v ? c : BUB; m.addr = v ? a : 15'h0; m.data = d;
      if (!v) m.bcnt = sat(m.bcnt);
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ND*DW-1:0] rand_data();
    logic [ND*DW-1:0] d;
    for (int i = 0; i < ND; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  function automatic exp_t observe();
    return '{valid: valid_out, ctrl: ctrl_out, addr: addr_out, data: data_out,
             bcnt: bubble_cnt, scnt: stall_cnt};
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 15'h0, {(ND*DW){1'b0}});
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset: got %h exp %h", o, e); end
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== BUB || addr_out !== 15'h0 || data_out !== {(ND*DW){1'b0}}) begin
      failures++; $display("FAIL reset_fields: got v=%b c=%h a=%h exp v=0 c=%h a=0", valid_out, ctrl_out, addr_out, BUB);
    end
  endtask

  task automatic test_load();
    logic [ND*DW-1:0] d;
    d = {(ND*DW){1'b0}}; d[31:0] = 32'h0000_1000;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 15'h1234, d);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL load: got %h exp %h", o, e); end
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== 16'h00A5 || data_out[31:0] !== 32'h0000_1000) begin
      failures++; $display("FAIL load_fields: got v=%b c=%h w0=%h exp v=1 c=00a5 w0=00001000", valid_out, ctrl_out, data_out[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom), 15'($urandom), rand_data());
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL load_rand%0d: got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_stall();
    logic [ND*DW-1:0] d;
    d = {(ND*DW){1'b0}}; d[31:0] = 32'h0000_1000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 15'h0, {(ND*DW){1'b0}});
    void'(sb.pop_front());
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 15'h0421, d);
    void'(sb.pop_front());
    d[31:0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h7E7E, 15'h7FFF, d);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL stall%0d: got %h exp %h", i, o, e); end
    end
    checks++;
    if (data_out[31:0] !== 32'h0000_1000 || stall_cnt !== (CNT_EN ? 4'd3 : 4'd0)) begin
      failures++; $display("FAIL stall_hold: got w0=%h scnt=%0d exp w0=00001000 scnt=%0d", data_out[31:0], stall_cnt, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 15'h2222, rand_data());
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h3333, 15'h4444, rand_data());
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL flush_stall: got %h exp %h", o, e); end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 15'h5555, rand_data());
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL bubble: got %h exp %h", o, e); end
    checks++;
    if (ctrl_out !== BUB || valid_out !== 1'b0 || addr_out !== 15'h0) begin
      failures++; $display("FAIL bubble_fields: got c=%h v=%b a=%h exp c=%h v=0 a=0", ctrl_out, valid_out, addr_out, BUB);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 15'h0, {(ND*DW){1'b0}});
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h00A5, 15'h0001, rand_data());
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL sat%0d: got %h exp %h", i, o, e); end
    end
    checks++;
    if (bubble_cnt !== (CNT_EN ? 4'hF : 4'h0)) begin
      failures++; $display("FAIL sat_final: got %h exp %h", bubble_cnt, CNT_EN ? 4'hF : 4'h0);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0ABC, 15'h0DEF, rand_data());
    void'(sb.pop_front());
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 15'h0F0F, rand_data());
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_mid: got %h exp %h", o, e); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0C3C, 15'h1357, rand_data());
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_then_load: got %h exp %h", o, e); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 3) != 0), 16'($urandom), 15'($urandom), rand_data());
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b%0d: got %h exp %h", i, o, e); end
    end
  endtask

  initial begin
    m = '0;
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_bubble();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
